bcd_to_bin: RTL

Sequential 4-digit packed-BCD to binary converter using reverse double-dabble (shift-right / subtract-3). It is the inverse companion of the lab's binary-to-BCD converter. It turns keypad or switch-entered decimal values into a binary value for the arithmetic datapath. It uses the same en/rdy start-and-done handshake as the forward converter, so both blocks sit side by side under one controller.

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_sub3_digit.sv | 14 +
 rtl/bcd_to_bin.sv | 92 +++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, state encodings and helpers for the BCD <-> binary converters.
package bcd_pkg;

  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 16;
  localparam int BIN_W      = 14;
  localparam int N_SHIFT    = 14;

  // Encodings shared with the forward binary-to-BCD converter.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SHIFT  = 3'd2,
    ADJUST = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] bcd);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_sub3_digit.sv
// Reverse double-dabble digit correction: nibbles of 8 or more lose 3.
module bcd_sub3_digit
  import bcd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_nibble = i_nibble;
    if (i_nibble >= 4'd8) o_nibble = i_nibble - 4'd3;
  end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, en/rdy handshake).
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = BCD_DIGITS,
  parameter int BIN_W  = bcd_pkg::BIN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DIGITS*4-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  rdy,
  output logic                  err,
  output logic                  busy
);

  localparam int W_W = DIGITS * 4 + BIN_W;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [W_W-1:0]      r_work;
  logic [DIGITS*4-1:0] r_hold;
  logic                r_err_flag;
  logic [W_W-1:0]      w_adj;

  assign w_adj[BIN_W-1:0] = r_work[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_sub3_digit u_sub3 (
      .i_nibble (r_work[BIN_W + 4*g +: 4]),
      .o_nibble (w_adj[BIN_W + 4*g +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_work     <= '0;
      r_hold     <= '0;
      r_err_flag <= 1'b0;
      bin_out    <= '0;
      rdy        <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // rdy from DONE lives for exactly this one IDLE cycle.
          rdy <= 1'b0;
          if (en) begin
            r_hold  <= bcd_in;
            busy    <= 1'b1;
            r_state <= SETUP;
          end else begin
            busy <= 1'b0;
          end
        end
        SETUP: begin
          if (has_bad_digit(r_hold)) begin
            r_err_flag <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_err_flag <= 1'b0;
            r_work     <= {r_hold, {BIN_W{1'b0}}};
            r_cnt      <= '0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_work <= r_work >> 1;
          r_cnt  <= r_cnt + 4'd1;
          if (r_cnt == 4'(N_SHIFT - 1)) r_state <= DONE;
          else                          r_state <= ADJUST;
        end
        ADJUST: begin
          r_work  <= w_adj;
          r_state <= SHIFT;
        end
        DONE: begin
          bin_out <= r_err_flag ? '0 : r_work[BIN_W-1:0];
          err     <= r_err_flag;
          rdy     <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
